// File: rtl/regfile_write_scheduler.sv
// Write-port scheduler for the 16 x 18-bit register file: round-robin arbitration
// between ALU (A) and load/immediate (B) writeback, plus a zeroing scrub sweep.
module regfile_write_scheduler #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                  CPU_CLOCK,
    input  logic                  CLEAR_N,
    input  logic                  A_VALID,
    input  logic [ADDR_WIDTH-1:0] A_REG,
    input  logic [DATA_WIDTH-1:0] A_DATA,
    output logic                  A_READY,
    input  logic                  B_VALID,
    input  logic [ADDR_WIDTH-1:0] B_REG,
    input  logic [DATA_WIDTH-1:0] B_DATA,
    output logic                  B_READY,
    input  logic                  SCRUB_START,
    output logic                  SCRUB_BUSY,
    output logic                  REG_WRITE_ENABLE,
    output logic [ADDR_WIDTH-1:0] WRITE_REG,
    output logic [DATA_WIDTH-1:0] WRITE_DATA
);

    typedef enum logic {ARB, SCRUB} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state;
    logic                  prio_b;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  arb_open;
    logic                  grant_a;
    logic                  grant_b;

    // Readies are gated by CLEAR_N so they read 0 the moment reset is asserted.
    assign arb_open = CLEAR_N && (state == ARB) && !SCRUB_START;
    assign grant_a  = arb_open && A_VALID && (!B_VALID || !prio_b);
    assign grant_b  = arb_open && B_VALID && (!A_VALID || prio_b);

    assign A_READY    = grant_a;
    assign B_READY    = grant_b;
    assign SCRUB_BUSY = (state == SCRUB);

    always_ff @(posedge CPU_CLOCK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            state            <= ARB;
            prio_b           <= 1'b0;
            cnt              <= '0;
            REG_WRITE_ENABLE <= 1'b0;
            WRITE_REG        <= '0;
            WRITE_DATA       <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (SCRUB_START) begin
                        state            <= SCRUB;
                        cnt              <= '0;
                        REG_WRITE_ENABLE <= 1'b0;
                    end else if (grant_a) begin
                        REG_WRITE_ENABLE <= 1'b1;
                        WRITE_REG        <= A_REG;
                        WRITE_DATA       <= A_DATA;
                        prio_b           <= 1'b1;
                    end else if (grant_b) begin
                        REG_WRITE_ENABLE <= 1'b1;
                        WRITE_REG        <= B_REG;
                        WRITE_DATA       <= B_DATA;
                        prio_b           <= 1'b0;
                    end else begin
                        REG_WRITE_ENABLE <= 1'b0;
                    end
                end
                SCRUB: begin
                    REG_WRITE_ENABLE <= 1'b1;
                    WRITE_REG        <= cnt;
                    WRITE_DATA       <= '0;
                    cnt              <= cnt + 1'b1;
                    if (cnt == LAST_REG) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared against
// a transaction-level model of the arbiter, scrub sweep and register file.
module tb_regfile_write_scheduler;

    localparam int DW = 18;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          CPU_CLOCK;
    logic          CLEAR_N;
    logic          A_VALID, B_VALID, A_READY, B_READY;
    logic [AW-1:0] A_REG, B_REG, WRITE_REG;
    logic [DW-1:0] A_DATA, B_DATA, WRITE_DATA;
    logic          SCRUB_START, SCRUB_BUSY, REG_WRITE_ENABLE;

    regfile_write_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .CPU_CLOCK(CPU_CLOCK), .CLEAR_N(CLEAR_N),
        .A_VALID(A_VALID), .A_REG(A_REG), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_REG(B_REG), .B_DATA(B_DATA), .B_READY(B_READY),
        .SCRUB_START(SCRUB_START), .SCRUB_BUSY(SCRUB_BUSY),
        .REG_WRITE_ENABLE(REG_WRITE_ENABLE), .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA)
    );

    initial begin
        CPU_CLOCK = 1'b0;
        forever #5 CPU_CLOCK = ~CPU_CLOCK;
    end

    int checkCount = 0;
    int errorCount = 0;

    // Register file image built only from what the DUT actually writes.
    logic [DW-1:0] dutRegs [NR];
    always @(posedge CPU_CLOCK) begin
        if (CLEAR_N && REG_WRITE_ENABLE) dutRegs[WRITE_REG] <= WRITE_DATA;
    end

    // Requester intentions and model state.
    bit          aPend, bPend, scrubReq;
    logic [AW-1:0] aReg, bReg;
    logic [DW-1:0] aData, bData;
    bit          mPrioB;
    int          mScrubLeft;
    bit          mWe;
    int          mReg, mData;
    int          scrubWritesSeen;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPrioB     = 1'b0;
        mScrubLeft = 0;
        mWe        = 1'b0;
        mReg       = 0;
        mData      = 0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check readies, advance model.
    task automatic applyStimulus();
        bit open, ga, gb;
        @(negedge CPU_CLOCK);
        checkOutput("we", REG_WRITE_ENABLE, mWe);
        checkOutput("wreg", WRITE_REG, mReg);
        checkOutput("wdata", WRITE_DATA, mData);
        checkOutput("busy", SCRUB_BUSY, mScrubLeft > 0);
        A_VALID = aPend; A_REG = aReg; A_DATA = aData;
        B_VALID = bPend; B_REG = bReg; B_DATA = bData;
        SCRUB_START = scrubReq;
        #1;
        open = (mScrubLeft == 0) && !scrubReq;
        ga = open && aPend && (!bPend || !mPrioB);
        gb = open && bPend && (!aPend || mPrioB);
        checkOutput("a_ready", A_READY, ga);
        checkOutput("b_ready", B_READY, gb);
        @(posedge CPU_CLOCK);
        if (mScrubLeft > 0) begin
            mWe = 1'b1; mReg = NR - mScrubLeft; mData = 0;
            mScrubLeft--;
            scrubWritesSeen++;
        end else if (scrubReq) begin
            mWe = 1'b0; mScrubLeft = NR;
        end else if (ga) begin
            mWe = 1'b1; mReg = aReg; mData = aData; mPrioB = 1'b1; aPend = 1'b0;
        end else if (gb) begin
            mWe = 1'b1; mReg = bReg; mData = bData; mPrioB = 1'b0; bPend = 1'b0;
        end else begin
            mWe = 1'b0;
        end
        scrubReq = 1'b0;
    endtask

    // Reset asserted mid-cycle with current requests visible; released just after an edge.
    task automatic doReset();
        @(negedge CPU_CLOCK);
        A_VALID = aPend; A_REG = aReg; A_DATA = aData;
        B_VALID = bPend; B_REG = bReg; B_DATA = bData;
        SCRUB_START = 1'b0;
        #2;
        CLEAR_N = 1'b0;
        #1;
        checkOutput("rst_we", REG_WRITE_ENABLE, 0);
        checkOutput("rst_wreg", WRITE_REG, 0);
        checkOutput("rst_wdata", WRITE_DATA, 0);
        checkOutput("rst_busy", SCRUB_BUSY, 0);
        checkOutput("rst_a_ready", A_READY, 0);
        checkOutput("rst_b_ready", B_READY, 0);
        modelReset();
        scrubReq = 1'b0;
        @(posedge CPU_CLOCK);
        #1;
        CLEAR_N = 1'b1;
    endtask

    task automatic refillA();
        aPend = 1'b1; aReg = AW'($urandom_range(NR - 1)); aData = DW'($urandom);
    endtask

    task automatic refillB();
        bPend = 1'b1; bReg = AW'($urandom_range(NR - 1)); bData = DW'($urandom);
    endtask

    initial begin
        CLEAR_N = 1'b0;
        A_VALID = 0; A_REG = '0; A_DATA = '0;
        B_VALID = 0; B_REG = '0; B_DATA = '0;
        SCRUB_START = 0;
        aPend = 0; bPend = 0; scrubReq = 0;
        aReg = '0; bReg = '0; aData = '0; bData = '0;
        scrubWritesSeen = 0;
        for (int i = 0; i < NR; i++) dutRegs[i] = '1;
        modelReset();
        #3;
        checkOutput("init_we", REG_WRITE_ENABLE, 0);
        checkOutput("init_busy", SCRUB_BUSY, 0);
        @(posedge CPU_CLOCK);
        #1;
        CLEAR_N = 1'b1;

        // Single requester A.
        aPend = 1; aReg = 4'd3; aData = 18'h2A5A3;
        applyStimulus();
        applyStimulus();
        applyStimulus();

        // Contention: both continuously valid, new data after each acceptance.
        for (int i = 0; i < 4; i++) begin
            if (!aPend) refillA();
            if (!bPend) refillB();
            applyStimulus();
        end
        for (int i = 0; i < 3; i++) applyStimulus();

        // Same register from both sides, presented across a reset so PRIO is A.
        aPend = 1; aReg = 4'd5; aData = 18'h00011;
        bPend = 1; bReg = 4'd5; bData = 18'h3FFFF;
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus();
        #1;
        checkOutput("same_reg_final", dutRegs[5], 18'h3FFFF);

        // Scrub with B waiting, plus an ignored second start mid-sweep.
        bPend = 1; bReg = 4'd9; bData = 18'h1ABCD;
        scrubReq = 1;
        applyStimulus();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) scrubReq = 1;
            applyStimulus();
        end
        #1;
        checkOutput("scrub_r3", dutRegs[3], 0);
        checkOutput("scrub_r5", dutRegs[5], 0);
        checkOutput("scrub_r9_b", dutRegs[9], 18'h1ABCD);

        // Reset after seven scrub writes, then restart the sweep.
        scrubReq = 1;
        applyStimulus();
        scrubWritesSeen = 0;
        for (int i = 0; i < 20 && scrubWritesSeen < 7; i++) applyStimulus();
        checkOutput("midscrub_count", scrubWritesSeen, 7);
        doReset();
        scrubReq = 1;
        for (int i = 0; i < 19; i++) applyStimulus();

        // Random traffic with occasional scrubs and resets.
        for (int i = 0; i < 400; i++) begin
            if (!aPend && $urandom_range(3) != 0) refillA();
            if (!bPend && $urandom_range(3) != 0) refillB();
            if ($urandom_range(39) == 0) scrubReq = 1;
            if ($urandom_range(99) == 0) doReset();
            else applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
